// File: rtl/xor_chain_sched.sv
// Round-robin scheduler sharing one iterative XOR-chain engine among NREQ requesters.
// Each accepted request computes a^b, then depth stages of acc ^ rotl1(acc), one per cycle.
module xor_chain_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH_W = 8,
    localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ*DEPTH_W-1:0]  req_depth,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic [15:0]              done_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id;
    logic [WIDTH-1:0]   acc;
    logic [DEPTH_W-1:0] cnt;

    logic [ID_W-1:0]    gidx;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [DEPTH_W-1:0] d_sel;
    logic [WIDTH-1:0]   acc_next;
    logic [NREQ-1:0]    vshift;
    logic               found;
    int                 idx;

    // Rotating-priority search from rr_ptr; also muxes out the winner's operands.
    always_comb begin
        req_ready = '0;
        gidx      = '0;
        a_sel     = '0;
        b_sel     = '0;
        d_sel     = '0;
        vshift    = '0;
        found     = 1'b0;
        idx       = 0;
        if (state == IDLE) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= int'(NREQ)) begin
                    idx = idx - int'(NREQ);
                end
                vshift = req_valid >> idx;
                if (!found && vshift[0]) begin
                    found     = 1'b1;
                    gidx      = ID_W'(idx);
                    req_ready = NREQ'(1) << idx;
                    a_sel     = WIDTH'(req_a >> (idx * int'(WIDTH)));
                    b_sel     = WIDTH'(req_b >> (idx * int'(WIDTH)));
                    d_sel     = DEPTH_W'(req_depth >> (idx * int'(DEPTH_W)));
                end
            end
        end
    end

    // One chain stage: XOR with a 1-bit left rotate of itself.
    assign acc_next = acc ^ {acc[WIDTH-2:0], acc[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id         <= '0;
            acc        <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            busy       <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        acc    <= a_sel ^ b_sel;
                        cnt    <= d_sel;
                        id     <= gidx;
                        rr_ptr <= (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + ID_W'(1);
                        busy   <= 1'b1;
                        if (d_sel != '0) begin
                            state <= RUN;
                        end else begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= a_sel ^ b_sel;
                            rsp_id    <= gidx;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - DEPTH_W'(1);
                    if (cnt == DEPTH_W'(1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= acc_next;
                        rsp_id    <= id;
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it; no same-cycle regrant.
                    if (rsp_ready) begin
                        state      <= IDLE;
                        rsp_valid  <= 1'b0;
                        busy       <= 1'b0;
                        done_count <= done_count + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_chain_sched.sv
// Directed bench for xor_chain_sched: depth chains, round-robin order, back-pressure, reset mid-run.
module tb_xor_chain_sched;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH_W = 8;
    localparam int unsigned ID_W    = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic [NREQ*DEPTH_W-1:0] req_depth;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [WIDTH-1:0]        rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic                    busy;
    logic [15:0]             done_count;

    logic [WIDTH-1:0]   a_arr [NREQ];
    logic [WIDTH-1:0]   b_arr [NREQ];
    logic [DEPTH_W-1:0] d_arr [NREQ];

    int checks = 0;
    int errors = 0;

    assign req_a     = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b     = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};
    assign req_depth = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};

    xor_chain_sched #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .DEPTH_W (DEPTH_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_depth  (req_depth),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
            d_arr[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [WIDTH-1:0] rr_data [NREQ] = '{8'h11, 8'h10, 8'h13, 8'h12};

    initial begin
        clear_reqs();
        rsp_ready = 1'b1;
        reset     = 1'b0;
        tick();
        do_reset();

        // Reset state
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_count", 32'(done_count), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Depth 0 request from requester 0
        a_arr[0] = 8'h0F; b_arr[0] = 8'h00; d_arr[0] = 8'd0; req_valid = 4'b0001;
        #1;
        chk("d0_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("d0_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("d0_rsp_data", 32'(rsp_data), 32'h0F);
        chk("d0_rsp_id", 32'(rsp_id), 32'd0);
        chk("d0_busy", 32'(busy), 32'd1);
        tick();
        chk("d0_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("d0_done_count", 32'(done_count), 32'd1);
        chk("d0_busy_idle", 32'(busy), 32'd0);

        // Depth 2: 0x0F -> 0x11 -> 0x33 (rr_ptr=1, wraps back to 0)
        d_arr[0] = 8'd2; req_valid = 4'b0001;
        #1;
        chk("d2_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("d2_run1_valid", 32'(rsp_valid), 32'd0);
        chk("d2_run1_busy", 32'(busy), 32'd1);
        tick();
        chk("d2_run2_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("d2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("d2_rsp_data", 32'(rsp_data), 32'h33);
        tick();
        chk("d2_done_count", 32'(done_count), 32'd2);

        // Depth 1: 0x0F -> 0x11
        d_arr[0] = 8'd1; req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("d1_run_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("d1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("d1_rsp_data", 32'(rsp_data), 32'h11);
        tick();
        chk("d1_done_count", 32'(done_count), 32'd3);

        // Round robin from a fresh reset: order 0,1,2,3,0
        clear_reqs();
        do_reset();
        for (int i = 0; i < int'(NREQ); i++) begin
            a_arr[i] = 8'(8'h10 + i);
            b_arr[i] = 8'h01;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % 4;
            chk("rr_req_ready", 32'(req_ready), 32'd1 << e);
            tick();
            chk("rr_req_ready_quiet", 32'(req_ready), 32'd0);
            chk("rr_rsp_id", 32'(rsp_id), 32'(e));
            chk("rr_rsp_data", 32'(rsp_data), 32'(rr_data[e]));
            tick();
        end
        chk("rr_done_count", 32'(done_count), 32'd5);

        // Back-pressure; also MSB rotate 0x80 -> 0x81. rr_ptr=1, requester 2 wins.
        clear_reqs();
        a_arr[2] = 8'h80; d_arr[2] = 8'd1; req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h81);
            chk("bp_rsp_id", 32'(rsp_id), 32'd2);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_count", 32'(done_count), 32'd6);
        chk("bp_next_grant", 32'(req_ready), 32'h8);
        req_valid = '0;
        tick();
        chk("bp_no_accept", 32'(busy), 32'd0);

        // Reset mid-RUN: depth 200, reset at run cycle 50; rr_ptr back to 0
        clear_reqs();
        d_arr[2] = 8'd200; a_arr[2] = 8'h5A; req_valid = 4'b0100;
        tick();
        req_valid = '0;
        for (int c = 0; c < 49; c++) begin
            tick();
        end
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_count", 32'(done_count), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("mid_rst_rr_ptr", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();
        chk("mid_rst_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
